// File: rtl/dmem_responder.sv
// dmem_responder: word-wide data memory for the MEM stage with a programmable
// number of wait states between request acceptance and response.
//
// Handshake rules (both channels): a transfer happens on a rising edge where
// valid and ready are both 1. req_ready is 1 only in IDLE. rsp_valid is 1
// only in RESP, and rsp_rdata/rsp_err stay constant until the response is
// taken. busy is the exact complement of req_ready.
//
// The access (error check, store commit, load read) happens on the edge that
// enters RESP. With WAIT_CYCLES = 0 that is the accept edge itself, so the
// access operands come straight from the request port in IDLE and from the
// latched copy in WAIT.
module dmem_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic [1:0]  stateDbg
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } stateT;

    stateT            state;
    stateT            stateNext;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cntNext;
    logic             accept;
    logic             doAccess;

    logic             latWrite;
    logic [31:0]      latAddr;
    logic [31:0]      latWdata;

    logic             accWrite;
    logic [31:0]      accAddr;
    logic [31:0]      accWdata;
    logic             accErr;
    logic [ADDR_W-1:0] accIdx;

    logic [31:0]      rdataQ;
    logic             errQ;
    logic [31:0]      mem [DEPTH];

    // State and wait counter; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Next-state logic, accept strobe and the access strobe on RESP entry.
    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        accept    = 1'b0;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept  = 1'b1;
                    cntNext = CNT_LOAD;
                    if (WAIT_CYCLES == 0) begin
                        stateNext = RESP;
                        doAccess  = 1'b1;
                    end else begin
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                // A counter at 0 here cannot happen; treat it like 1 so the
                // FSM can never stall or wrap.
                if (cnt <= CNT_ONE) begin
                    stateNext = RESP;
                    doAccess  = 1'b1;
                    cntNext   = '0;
                end else begin
                    cntNext = cnt - CNT_ONE;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Access operands: live request on the accept edge, latched copy later.
    always_comb begin
        accWrite = latWrite;
        accAddr  = latAddr;
        accWdata = latWdata;
        if (state == IDLE) begin
            accWrite = req_write;
            accAddr  = req_addr;
            accWdata = req_wdata;
        end
        accErr = (accAddr[1:0] != 2'b00) || ((accAddr >> (ADDR_W + 2)) != 32'd0);
        accIdx = accAddr[ADDR_W+1:2];
    end

    // Request capture on the accept edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latWrite <= 1'b0;
            latAddr  <= '0;
            latWdata <= '0;
        end else if (accept) begin
            latWrite <= req_write;
            latAddr  <= req_addr;
            latWdata <= req_wdata;
        end
    end

    // Response registers, loaded once per transaction on RESP entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdataQ <= '0;
            errQ   <= 1'b0;
        end else if (doAccess) begin
            errQ   <= accErr;
            rdataQ <= (!accWrite && !accErr) ? mem[accIdx] : 32'd0;
        end
    end

    // Storage array; not reset, and no commit while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n && doAccess && accWrite && !accErr) begin
            mem[accIdx] <= accWdata;
        end
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;
    assign stateDbg  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (WAIT_CYCLES 2, 0, 15) sharing
// one clock. Drivers push expected responses from a word-array model into a
// per-instance queue; one monitor pops and compares on every response
// handshake, and also watches latency, hold stability and busy/req_ready.
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        bit          known;
    } expT;

    logic        clk;
    logic        rstN      [3];
    logic        reqValid  [3];
    logic        reqReady  [3];
    logic        reqWrite  [3];
    logic [31:0] reqAddr   [3];
    logic [31:0] reqWdata  [3];
    logic        rspValid  [3];
    logic        rspReady  [3];
    logic [31:0] rspRdata  [3];
    logic        rspErr    [3];
    logic        busy      [3];
    logic [1:0]  stateDbg  [3];

    expT         expQ      [3][$];
    logic [31:0] refMem    [3][256];
    bit          refKnown  [3][256];
    bit          randReady [3];

    int          checks = 0;
    int          errors = 0;
    int          edgeCnt = 0;
    int          lastAcceptEdge [3];

    // monitor bookkeeping
    bit          pending    [3];
    int          acceptEdge [3];
    bit          prevValid  [3];
    bit          prevHeld   [3];
    logic [31:0] prevData   [3];
    logic        prevErr    [3];

    for (genvar g = 0; g < 3; g++) begin : gDut
        dmem_responder #(
            .ADDR_W     (8),
            .WAIT_CYCLES(g == 0 ? 2 : (g == 1 ? 0 : 15))
        ) uDut (
            .clk      (clk),
            .rst_n    (rstN[g]),
            .req_valid(reqValid[g]),
            .req_ready(reqReady[g]),
            .req_write(reqWrite[g]),
            .req_addr (reqAddr[g]),
            .req_wdata(reqWdata[g]),
            .rsp_valid(rspValid[g]),
            .rsp_ready(rspReady[g]),
            .rsp_rdata(rspRdata[g]),
            .rsp_err  (rspErr[g]),
            .busy     (busy[g]),
            .stateDbg (stateDbg[g])
        );
    end

    function automatic int waitOf(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 15);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not allowed here", name);
    endtask

    // clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) edgeCnt <= edgeCnt + 1;

    // random response backpressure where enabled
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++) begin
            if (randReady[d]) rspReady[d] = 1'($urandom_range(0, 1));
        end
    end

    // Issue one request; optionally record its expected response in the model.
    task automatic issue(input int d, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input bit track, input bit hold);
        expT e;
        bit  ok;
        int  guard;
        int  idx;
        idx = int'(addr[9:2]);
        if (track) begin
            e.err = (addr[1:0] != 2'b00) || (addr[31:10] != 22'd0);
            if (e.err) begin
                e.rdata = 32'd0;
                e.known = 1'b1;
            end else if (wr) begin
                e.rdata = 32'd0;
                e.known = 1'b1;
                refMem[d][idx]   = wdata;
                refKnown[d][idx] = 1'b1;
            end else begin
                e.rdata = refMem[d][idx];
                e.known = refKnown[d][idx];
            end
            expQ[d].push_back(e);
        end
        reqValid[d] = 1'b1;
        reqWrite[d] = wr;
        reqAddr[d]  = addr;
        reqWdata[d] = wdata;
        ok = 1'b0;
        guard = 0;
        while (!ok && guard < 300) begin
            @(negedge clk);
            if (reqReady[d]) ok = 1'b1;
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) failNow($sformatf("d%0d_accept_timeout", d));
        lastAcceptEdge[d] = edgeCnt;
        if (!hold) reqValid[d] = 1'b0;
    endtask

    task automatic waitIdle(input int d);
        int guard;
        guard = 0;
        while ((busy[d] || expQ[d].size() != 0) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 500) failNow($sformatf("d%0d_idle_timeout", d));
    endtask

    // Monitor: response scoreboard, latency, hold stability, reset values.
    // Latency counts rising edges from the accept edge (inclusive) to the
    // edge on which rsp_valid rises: WAIT_CYCLES + 1.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rstN[d]) begin
                check($sformatf("d%0d_rst_state", d), 32'(stateDbg[d]), 32'd0);
                check($sformatf("d%0d_rst_req_ready", d), 32'(reqReady[d]), 32'd1);
                check($sformatf("d%0d_rst_rsp_valid", d), 32'(rspValid[d]), 32'd0);
                check($sformatf("d%0d_rst_rdata", d), rspRdata[d], 32'd0);
                check($sformatf("d%0d_rst_err", d), 32'(rspErr[d]), 32'd0);
                check($sformatf("d%0d_rst_busy", d), 32'(busy[d]), 32'd0);
                pending[d]  = 1'b0;
                prevHeld[d] = 1'b0;
            end else begin
                check($sformatf("d%0d_busy_vs_ready", d), 32'(busy[d]), 32'(!reqReady[d]));
                if (prevHeld[d]) begin
                    check($sformatf("d%0d_valid_held", d), 32'(rspValid[d]), 32'd1);
                    check($sformatf("d%0d_rdata_held", d), rspRdata[d], prevData[d]);
                    check($sformatf("d%0d_err_held", d), 32'(rspErr[d]), 32'(prevErr[d]));
                end
                if (rspValid[d]) begin
                    if (!prevValid[d]) begin
                        if (pending[d])
                            check($sformatf("d%0d_latency", d),
                                  32'(edgeCnt - acceptEdge[d] + 1), 32'(waitOf(d) + 1));
                        else
                            failNow($sformatf("d%0d_rsp_without_accept", d));
                        pending[d] = 1'b0;
                    end
                    if (rspReady[d]) begin
                        if (expQ[d].size() == 0) begin
                            failNow($sformatf("d%0d_unexpected_rsp", d));
                        end else begin
                            expT e;
                            e = expQ[d].pop_front();
                            check($sformatf("d%0d_rsp_err", d), 32'(rspErr[d]), 32'(e.err));
                            if (e.known)
                                check($sformatf("d%0d_rsp_rdata", d), rspRdata[d], e.rdata);
                        end
                    end
                end
                if (reqValid[d] && reqReady[d]) begin
                    pending[d]    = 1'b1;
                    acceptEdge[d] = edgeCnt + 1;
                end
                prevHeld[d] = rspValid[d] && !rspReady[d];
                prevData[d] = rspRdata[d];
                prevErr[d]  = rspErr[d];
            end
            prevValid[d] = rspValid[d];
        end
    end

    // Stimulus
    initial begin
        int guard;
        for (int d = 0; d < 3; d++) begin
            rstN[d]      = 1'b0;
            reqValid[d]  = 1'b0;
            reqWrite[d]  = 1'b0;
            reqAddr[d]   = '0;
            reqWdata[d]  = '0;
            rspReady[d]  = 1'b1;
            randReady[d] = 1'b0;
            pending[d]   = 1'b0;
            prevValid[d] = 1'b0;
            prevHeld[d]  = 1'b0;
            for (int i = 0; i < 256; i++) refKnown[d][i] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rstN[d] = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("d%0d_post_rst_req_ready", d), 32'(reqReady[d]), 32'd1);
            check($sformatf("d%0d_post_rst_rsp_valid", d), 32'(rspValid[d]), 32'd0);
            check($sformatf("d%0d_post_rst_busy", d), 32'(busy[d]), 32'd0);
        end
        @(posedge clk);
        #1;

        // WAIT_CYCLES = 2: store/load, misaligned, out of range
        issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b1, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        issue(0, 1'b1, 32'h13, 32'h12345678, 1'b1, 1'b0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        issue(0, 1'b0, 32'h400, 32'h0, 1'b1, 1'b0);
        waitIdle(0);

        // Backpressure with ignored requests during the hold
        rspReady[0] = 1'b0;
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        guard = 0;
        while (!rspValid[0] && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) failNow("d0_bp_rsp_timeout");
        for (int i = 0; i < 5; i++) begin
            reqValid[0] = 1'b1;
            reqWrite[0] = 1'b1;
            reqAddr[0]  = 32'h10;
            reqWdata[0] = 32'hBAD0BAD0;
            @(negedge clk);
            check("d0_bp_rsp_valid", 32'(rspValid[0]), 32'd1);
            check("d0_bp_busy", 32'(busy[0]), 32'd1);
            check("d0_bp_req_ready", 32'(reqReady[0]), 32'd0);
            check("d0_bp_rdata", rspRdata[0], 32'hDEADBEEF);
            @(posedge clk);
            #1;
        end
        reqValid[0] = 1'b0;
        rspReady[0] = 1'b1;
        waitIdle(0);
        issue(0, 1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
        waitIdle(0);

        // Reset during WAIT drops the uncommitted store
        issue(0, 1'b1, 32'h20, 32'hCAFEF00D, 1'b1, 1'b0);
        waitIdle(0);
        issue(0, 1'b1, 32'h20, 32'h11111111, 1'b0, 1'b0);
        rstN[0] = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1;
        rstN[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("d0_after_abort_rsp_valid", 32'(rspValid[0]), 32'd0);
            check("d0_after_abort_state", 32'(stateDbg[0]), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h20, 32'h0, 1'b1, 1'b0);
        waitIdle(0);

        // WAIT_CYCLES = 0: back-to-back stores with req_valid held high
        for (int i = 0; i < 4; i++) begin
            int prevEdge;
            prevEdge = lastAcceptEdge[1];
            issue(1, 1'b1, 32'(i * 4), 32'(i + 1), 1'b1, (i < 3));
            if (i > 0) check("d1_accept_spacing", 32'(lastAcceptEdge[1] - prevEdge), 32'd2);
        end
        for (int i = 0; i < 4; i++) issue(1, 1'b0, 32'(i * 4), 32'h0, 1'b1, 1'b0);
        waitIdle(1);

        // WAIT_CYCLES = 15: long latency, counter must not wrap
        issue(2, 1'b1, 32'h40, 32'hA5A5_5A5A, 1'b1, 1'b0);
        issue(2, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0);
        waitIdle(2);

        // Randomized traffic with random response backpressure
        for (int d = 0; d < 3; d++) begin
            randReady[d] = 1'b1;
            for (int n = 0; n < 30; n++) begin
                int          sel;
                logic [31:0] a;
                logic [31:0] w;
                sel = $urandom_range(0, 9);
                a   = 32'($urandom_range(0, 15)) << 2;
                if (sel == 7) a = a + 32'($urandom_range(1, 3));
                else if (sel == 8) a = a | (32'($urandom_range(1, 255)) << 10);
                else if (sel == 9) a = $urandom;
                w = $urandom;
                issue(d, 1'($urandom_range(0, 1)), a, w, 1'b1, 1'b0);
            end
            waitIdle(d);
            randReady[d] = 1'b0;
            @(posedge clk);
            #1;
            rspReady[d] = 1'b1;
        end

        repeat (4) @(posedge clk);
        for (int d = 0; d < 3; d++)
            check($sformatf("d%0d_queue_drained", d), 32'(expQ[d].size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
